// File: rtl/disc_counter_pkg.sv
// Shared definitions for the discriminator counter bank: FSM state
// encoding and the default channel, counter and gate-timer sizes.
package disc_counter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEF_N_CH   = 4;
   localparam int DEF_CNT_W  = 16;
   localparam int DEF_GATE_W = 24;

endpackage

// File: rtl/disc_edge_det.sv
// Falling-edge detector for one active-low discriminator input.
// Build option DISC_SYNC_EN inserts a 2-flop synchronizer in front of the
// edge register (fall reported one cycle later than the direct build).
// All pipeline stages reset to 1. An "armed" bit is only set once the
// pipeline has carried a genuine high sample, so a reset release while the
// input is held low never produces a fall until the input rises again.
module disc_edge_det (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_disc,
   output logic o_fall
);

   logic w_cur;
   logic w_filled;
   logic r_edge;
   logic r_armed;

`ifdef DISC_SYNC_EN
   logic       r_sync1;
   logic       r_sync2;
   logic [1:0] r_fill;

   // Two-flop synchronizer plus a fill tracker marking when r_sync2 holds real data
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_fill  <= 2'b00;
      end else begin
         r_sync1 <= i_disc;
         r_sync2 <= r_sync1;
         r_fill  <= {r_fill[0], 1'b1};
      end
   end

   assign w_cur    = r_sync2;
   assign w_filled = r_fill[1];
`else
   logic r_samp;
   logic r_filled;

   // Direct input sample plus a flag marking when r_samp holds real data
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_samp   <= 1'b1;
         r_filled <= 1'b0;
      end else begin
         r_samp   <= i_disc;
         r_filled <= 1'b1;
      end
   end

   assign w_cur    = r_samp;
   assign w_filled = r_filled;
`endif

   // Edge register keeps the previous sample; armed latches the first real high
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_edge  <= 1'b1;
         r_armed <= 1'b0;
      end else begin
         r_edge <= w_cur;
         if (w_filled && w_cur) begin
            r_armed <= 1'b1;
         end
      end
   end

   assign o_fall = r_armed & r_edge & ~w_cur;

endmodule

// File: rtl/disc_counter_bank.sv
// Gated bank of per-channel falling-edge counters. A start pulse opens a
// window of max(gate_len,1) enabled cycles; at the end the working counts
// and overflow flags are copied to the snapshot outputs with a done pulse.
// Build option DISC_SYNC_EN adds input synchronizers inside disc_edge_det.
module disc_counter_bank
   import disc_counter_pkg::*;
#(
   parameter int N_CH     = DEF_N_CH,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int GATE_W   = DEF_GATE_W,
   parameter int SATURATE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear,
   input  logic [GATE_W-1:0]     gate_len,
   input  logic [N_CH-1:0]       disc,
   output logic                  busy,
   output logic                  done,
   output logic [N_CH*CNT_W-1:0] count,
   output logic [N_CH-1:0]       ovf
);

   state_t                       r_state;
   state_t                       w_nextState;
   logic [GATE_W-1:0]            r_timer;
   logic [N_CH-1:0][CNT_W-1:0]   r_work;
   logic [N_CH-1:0][CNT_W-1:0]   r_snap;
   logic [N_CH-1:0]              r_workOvf;
   logic [N_CH-1:0]              r_snapOvf;
   logic                         r_done;
   logic [N_CH-1:0]              w_fall;
   logic                         w_enter;
   logic                         w_countEn;
   logic                         w_snapEn;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      disc_edge_det u_det (
         .i_clk  (clk),
         .i_rst  (rst),
         .i_disc (disc[g]),
         .o_fall (w_fall[g])
      );
   end

   // A coincident stop suppresses opening a window
   assign w_enter   = (r_state == IDLE) & we & start & ~stop;
   assign w_countEn = (r_state == COUNT) & we;
   assign w_snapEn  = (r_state == DONE) & we;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic; everything holds while we is low
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_enter) begin
               w_nextState = COUNT;
            end
         end
         COUNT: begin
            if (we) begin
               if (stop) begin
                  w_nextState = IDLE;
               end else if (r_timer == GATE_W'(1)) begin
                  w_nextState = DONE;
               end
            end
         end
         DONE: begin
            if (we) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Window-open indication covers COUNT and DONE
   always_comb begin
      busy = (r_state == COUNT) || (r_state == DONE);
   end

   // Gate timer: loads the window length on entry, counts down while enabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timer <= '0;
      end else if (w_enter) begin
         r_timer <= (gate_len == '0) ? GATE_W'(1) : gate_len;
      end else if (w_countEn) begin
         r_timer <= r_timer - GATE_W'(1);
      end
   end

   // Working counters: cleared on entry, bumped by each detected fall in COUNT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_work    <= '0;
         r_workOvf <= '0;
      end else if (w_enter) begin
         r_work    <= '0;
         r_workOvf <= '0;
      end else if (w_countEn) begin
         for (int i = 0; i < N_CH; i++) begin
            if (w_fall[i]) begin
               if (r_work[i] == {CNT_W{1'b1}}) begin
                  r_workOvf[i] <= 1'b1;
                  if (SATURATE == 0) begin
                     r_work[i] <= '0;
                  end
               end else begin
                  r_work[i] <= r_work[i] + CNT_W'(1);
               end
            end
         end
      end
   end

   // Snapshot outputs and done pulse; a snapshot takes priority over clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_snap    <= '0;
         r_snapOvf <= '0;
         r_done    <= 1'b0;
      end else if (w_snapEn) begin
         r_snap    <= r_work;
         r_snapOvf <= r_workOvf;
         r_done    <= 1'b1;
      end else begin
         r_done <= 1'b0;
         if (clear) begin
            r_snap    <= '0;
            r_snapOvf <= '0;
         end
      end
   end

   assign count = r_snap;
   assign ovf   = r_snapOvf;
   assign done  = r_done;

endmodule

// File: tb/tb_disc_counter_bank.sv
// Self-checking bench for disc_counter_bank. Expected window results come
// from a small edge-count model and are queued when a window's stimulus is
// issued, then popped and compared when done fires. Two extra 4-bit
// instances (saturating and wrapping) share the same stimulus.
// Honours DISC_SYNC_EN for the edge latency.
module tb_disc_counter_bank;

`ifdef DISC_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic [63:0] cnt;
      logic [3:0]  ovf;
      logic [15:0] cntS;
      logic [3:0]  ovfS;
      logic [15:0] cntW;
      logic [3:0]  ovfW;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic        start;
   logic        stop;
   logic        clear;
   logic [23:0] gate_len;
   logic [3:0]  disc;
   logic        busy,  done;
   logic [63:0] count;
   logic [3:0]  ovf;
   logic        busyS, doneS;
   logic [15:0] countS;
   logic [3:0]  ovfS;
   logic        busyW, doneW;
   logic [15:0] countW;
   logic [3:0]  ovfW;

   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;
   int   s          = 0;
   exp_t sb[$];
   exp_t lastExp;
   logic sawDone;
   logic [3:0] d;

   always #5 clk = ~clk;

   disc_counter_bank dut (
      .clk(clk), .rst(rst), .we(we), .start(start), .stop(stop), .clear(clear),
      .gate_len(gate_len), .disc(disc), .busy(busy), .done(done), .count(count), .ovf(ovf)
   );

   disc_counter_bank #(.CNT_W(4), .SATURATE(1)) dutSat (
      .clk(clk), .rst(rst), .we(we), .start(start), .stop(stop), .clear(clear),
      .gate_len(gate_len), .disc(disc), .busy(busyS), .done(doneS), .count(countS), .ovf(ovfS)
   );

   disc_counter_bank #(.CNT_W(4), .SATURATE(0)) dutWrap (
      .clk(clk), .rst(rst), .we(we), .start(start), .stop(stop), .clear(clear),
      .gate_len(gate_len), .disc(disc), .busy(busyW), .done(doneW), .count(countW), .ovf(ovfW)
   );

   // Expected snapshot for a window given the number of counted falls per channel
   function automatic exp_t model(input int e0, input int e1, input int e2, input int e3);
      exp_t r;
      int   n[4];
      n[0] = e0; n[1] = e1; n[2] = e2; n[3] = e3;
      for (int c = 0; c < 4; c++) begin
         r.cnt[c*16 +: 16] = 16'(n[c]);
         r.ovf[c]          = (n[c] > 65535);
         r.cntS[c*4 +: 4]  = (n[c] > 15) ? 4'hF : 4'(n[c]);
         r.ovfS[c]         = (n[c] > 15);
         r.cntW[c*4 +: 4]  = 4'(n[c] % 16);
         r.ovfW[c]         = (n[c] > 15);
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic iWe, input logic iStart, input logic iStop, input logic [3:0] iDisc);
      we    = iWe;
      start = iStart;
      stop  = iStop;
      disc  = iDisc;
      tick();
   endtask

   // Wait for done, check its cycle, pop the scoreboard and compare the snapshot
   task automatic waitDone(input string tag, input int expCyc);
      exp_t e;
      int   n = 0;
      while (done !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      checkOutput({tag, ".doneAt"}, 64'(cyc), 64'(expCyc));
      if (sb.size() == 0) begin
         mismatched++;
         $error("[TB] FAIL %s.scoreboard: observed empty queue, required one entry", tag);
      end else begin
         e = sb.pop_front();
         checkOutput({tag, ".count"},  count,       e.cnt);
         checkOutput({tag, ".ovf"},    64'(ovf),    64'(e.ovf));
         checkOutput({tag, ".countS"}, 64'(countS), 64'(e.cntS));
         checkOutput({tag, ".ovfS"},   64'(ovfS),   64'(e.ovfS));
         checkOutput({tag, ".countW"}, 64'(countW), 64'(e.cntW));
         checkOutput({tag, ".ovfW"},   64'(ovfW),   64'(e.ovfW));
         checkOutput({tag, ".doneS"},  64'(doneS),  64'd1);
         checkOutput({tag, ".doneW"},  64'(doneW),  64'd1);
         lastExp = e;
      end
      tick();
      checkOutput({tag, ".donePulse"}, 64'(done), 64'd0);
      checkOutput({tag, ".busyAfter"}, 64'(busy), 64'd0);
   endtask

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence
   initial begin
      rst = 1'b1; we = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
      gate_len = '0; disc = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.busy",  64'(busy),  64'd0);
      checkOutput("reset.done",  64'(done),  64'd0);
      checkOutput("reset.count", count,      64'd0);
      checkOutput("reset.ovf",   64'(ovf),   64'd0);
      checkOutput("reset.busyS", 64'(busyS), 64'd0);
      checkOutput("reset.busyW", 64'(busyW), 64'd0);
      rst = 1'b0;
      repeat (3) tick();

      // Basic window: 3 pulses on ch0, 5 on ch2, gate of 10
      gate_len = 24'd10;
      sb.push_back(model(3, 0, 5, 0));
      for (int j = 0; j < 5; j++) begin
         applyStimulus(1'b1, j == 0, 1'b0, (j < 3) ? 4'b1010 : 4'b1011);
         if (j == 0) begin
            s = cyc;
            checkOutput("t1.busyOpen", 64'(busy), 64'd1);
         end
         applyStimulus(1'b1, 1'b0, 1'b0, 4'hF);
      end
      tick();
      checkOutput("t1.busyInDone", 64'(busy), 64'd1);
      checkOutput("t1.noEarlyDone", 64'(done), 64'd0);
      waitDone("t1", s + 11);

      // Idle pulses ignored, start re-trigger ignored, long low level counts once
      for (int j = 0; j < 3; j++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 4'b0111);
         applyStimulus(1'b1, 1'b0, 1'b0, 4'hF);
      end
      repeat (3) tick();
      gate_len = 24'd30;
      sb.push_back(model(0, 1, 0, 0));
      for (int t = 0; t < 24; t++) begin
         applyStimulus(1'b1, (t == 0) || (t == 5), 1'b0, (t >= 1 && t <= 20) ? 4'b1101 : 4'hF);
         if (t == 0) s = cyc;
      end
      waitDone("t2", s + 31);

      // Last-cycle boundary on ch0 (in) and ch1 (out), clear held throughout
      gate_len = 24'd6;
      clear = 1'b1;
      sb.push_back(model(1, 0, 0, 0));
      for (int t = 0; t < 7; t++) begin
         d = 4'hF;
         if (t == 6 - LAT) d[0] = 1'b0;
         if (t == 7 - LAT) d[1] = 1'b0;
         applyStimulus(1'b1, t == 0, 1'b0, d);
         if (t == 0) s = cyc;
      end
      disc = 4'hF;
      waitDone("t6", s + 7);
      checkOutput("t6.clearCount", count,    64'd0);
      checkOutput("t6.clearOvf",   64'(ovf), 64'd0);
      clear = 1'b0;

      // 20 edges on ch0: 16-bit counts 20, 4-bit saturates or wraps
      gate_len = 24'd50;
      sb.push_back(model(20, 0, 0, 0));
      for (int t = 0; t < 40; t++) begin
         applyStimulus(1'b1, t == 0, 1'b0, (t % 2 == 0) ? 4'b1110 : 4'hF);
         if (t == 0) s = cyc;
      end
      waitDone("t3", s + 51);

      // Stop aborts a long window; snapshot is kept and no done appears
      gate_len = 24'd100;
      for (int t = 0; t < 5; t++) begin
         applyStimulus(1'b1, t == 0, 1'b0, (t == 2) ? 4'b1110 : 4'hF);
      end
      checkOutput("t4.busyBeforeStop", 64'(busy), 64'd1);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'hF);
      checkOutput("t4.busyAfterStop", 64'(busy), 64'd0);
      sawDone = 1'b0;
      repeat (110) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 4'hF);
         sawDone = sawDone | done;
      end
      checkOutput("t4.noDone",    64'(sawDone), 64'd0);
      checkOutput("t4.countKept", count,        lastExp.cnt);
      checkOutput("t4.ovfKept",   64'(ovf),     64'(lastExp.ovf));
      applyStimulus(1'b1, 1'b1, 1'b1, 4'hF);
      checkOutput("t4.stopWinsStart", 64'(busy), 64'd0);

      // Enable low for three cycles stretches the window by three
      gate_len = 24'd4;
      sb.push_back(model(1, 0, 0, 0));
      for (int t = 0; t < 7; t++) begin
         applyStimulus(!(t >= 2 && t <= 4), t == 0, 1'b0, (t == 5) ? 4'b1110 : 4'hF);
         if (t == 0) s = cyc;
      end
      waitDone("t5", s + 8);

      // Reset mid-window with ch3 low clears outputs at once
      gate_len = 24'd20;
      for (int t = 0; t < 6; t++) begin
         applyStimulus(1'b1, t == 0, 1'b0, (t == 1) ? 4'b1011 : ((t >= 4) ? 4'b0111 : 4'hF));
      end
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t7.rstBusy",  64'(busy), 64'd0);
      checkOutput("t7.rstDone",  64'(done), 64'd0);
      checkOutput("t7.rstCount", count,     64'd0);
      checkOutput("t7.rstOvf",   64'(ovf),  64'd0);
      #1;
      rst = 1'b0;

      // Window of gate_len 0 right after release: one cycle, ch3 still low, no count
      gate_len = 24'd0;
      sb.push_back(model(0, 0, 0, 0));
      applyStimulus(1'b1, 1'b1, 1'b0, 4'b0111);
      s = cyc;
      start = 1'b0;
      waitDone("t7a", s + 2);

      // ch3 rises then falls again inside a window: counted once
      gate_len = 24'd8;
      sb.push_back(model(0, 0, 0, 1));
      for (int t = 0; t < 6; t++) begin
         applyStimulus(1'b1, t == 0, 1'b0, (t == 2 || t == 3) ? 4'hF : 4'b0111);
         if (t == 0) s = cyc;
      end
      waitDone("t7b", s + 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/disc_counter_bank.md
DISC_COUNTER_BANK -- requirements
Module: disc_counter_bank

Interface
REQ-001 The block SHALL take parameter N_CH, default 4: number of discriminator channels (1..16).
REQ-002 The block SHALL take parameter CNT_W, default 16: per-channel counter width.
REQ-003 The block SHALL take parameter GATE_W, default 24: width of the gate-length timer.
REQ-004 The block SHALL take parameter SATURATE, default 1: 1 = counters saturate at max, 0 = counters wrap.
REQ-005 The block SHALL have one clock and asynchronous active-high reset, ports `clk  in  1  clock` and `rst  in  1  async reset, active-high`.
REQ-006 The block SHALL have port `we  in  1  enable`; when low, the FSM, the timer and all counters hold.
REQ-007 The block SHALL have port `start  in  1  pulse that opens a gate window`.
REQ-008 The block SHALL have port `stop  in  1  pulse that aborts an open window`.
REQ-009 The block SHALL have port `clear  in  1  zeroes the snapshot outputs`.
REQ-010 The block SHALL have port `gate_len  in  GATE_W  window length in clk cycles`.
REQ-011 The block SHALL have port `disc  in  N_CH  discriminator inputs, active-low`.
REQ-012 The block SHALL have port `busy  out  1  window open`.
REQ-013 The block SHALL have port `done  out  1  one-cycle pulse when a snapshot is taken`.
REQ-014 The block SHALL have port `count  out  N_CH*CNT_W  snapshot counts, channel i at [i*CNT_W +: CNT_W]`.
REQ-015 The block SHALL have port `ovf  out  N_CH  snapshot per-channel overflow flags`.

Function
REQ-016 The block SHALL count falling edges (high-to-low transitions) of each disc bit, not low cycles; channels are fully independent with no priority between them.
REQ-017 The FSM SHALL have three states: IDLE, COUNT, DONE.
REQ-018 IDLE -> COUNT SHALL occur on `start & we`; on entry the working counters and overflow flags SHALL clear and the timer SHALL load max(gate_len, 1).
REQ-019 In COUNT with we=1, the timer SHALL decrement each cycle; timer==1 SHALL transition to DONE; the window therefore lasts exactly max(gate_len, 1) enabled cycles.
REQ-020 An edge detected in any COUNT cycle, including the last one, SHALL be counted in that window.
REQ-021 DONE SHALL copy the working counters and overflow flags to count and ovf, assert done for 1 cycle, and return to IDLE.
REQ-022 busy SHALL be high in COUNT and DONE only.
REQ-023 stop in COUNT SHALL return to IDLE with no snapshot and no done pulse.
REQ-024 stop SHALL win over a coincident start.
REQ-025 start in COUNT or DONE SHALL be ignored.
REQ-026 At max value, an edge SHALL hold the counter at all-ones when SATURATE=1 and wrap it to 0 when SATURATE=0; either way the channel overflow flag SHALL set and stay set for the window.
REQ-027 clear SHALL zero count and ovf in any state; a coincident DONE snapshot SHALL win over clear.
REQ-028 Edges outside COUNT SHALL be ignored.

Reset
REQ-029 rst SHALL asynchronously force the FSM to IDLE, the timer and working counters to 0, count/ovf/done/busy to 0, and all edge-detector stages to 1, so a reset release with disc low generates no spurious edge until disc returns high.

Configuration
REQ-030 The block SHALL support macro DISC_SYNC_EN.
REQ-031 With DISC_SYNC_EN defined, each disc bit SHALL pass through a 2-flop synchronizer before the edge register; a first low sample at posedge k SHALL be counted at posedge k+2.
REQ-032 Without DISC_SYNC_EN, the edge register SHALL sample disc directly; the same edge SHALL be counted at posedge k+1.

Structure
REQ-033 Package disc_counter_pkg SHALL hold the FSM state enum (IDLE, COUNT, DONE) and the default N_CH, CNT_W and GATE_W constants.
REQ-034 Sub-module disc_edge_det (synchronizer, edge register, one-cycle fall output) SHALL be instantiated once per channel.

Verification
REQ-035 gate_len=10, start, 3 clean pulses on disc[0] and 5 on disc[2] inside the window -> done after 10 COUNT cycles; count ch0=3, ch1=0, ch2=5, ch3=0; ovf=0.
REQ-036 disc[1] held low for 20 cycles within the window -> count ch1=1; a low level alone SHALL NOT increment.
REQ-037 CNT_W=4, 20 edges on ch0: SATURATE=1 -> count=15, ovf[0]=1; SATURATE=0 -> count=4, ovf[0]=1.
REQ-038 stop issued 5 cycles into a gate_len=100 window -> busy drops the next cycle, done never asserts, count keeps the previous snapshot.
REQ-039 Edge timed so its fall reaches the counter in the last COUNT cycle -> included; one cycle later -> excluded. Repeat with and without DISC_SYNC_EN, checking the k+2 / k+1 latency.
REQ-040 rst asserted mid-window with disc low -> all outputs 0 immediately; after release with disc still low, no count until disc rises and falls again; gate_len=0 -> window lasts 1 cycle.
